// File: rtl/pusch_mod_mapper.sv
// PUSCH modulation mapper: gathers Qm serial bits per symbol, maps them to a QPSK/16QAM/64QAM
// point and writes it into the ping-pong symbol memory, flagging the end of each block.
module pusch_mod_mapper #(
    parameter int unsigned MEM_DEPTH  = 1200,
    parameter int unsigned DATA_WIDTH = 18
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [1:0]            mod_order,
    input  logic [10:0]           num_symbols,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic [DATA_WIDTH-1:0] sym_out,
    output logic                  Mod_Valid_OUT,
    output logic                  write_enable,
    output logic [10:0]           write_addr,
    output logic                  MOD_DONE,
    output logic                  PINGPONG_SWITCH,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            qm_q, qm_d;
    logic [10:0]           n_q, n_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [10:0]           sym_cnt_q, sym_cnt_d;
    logic [5:0]            grp_q, grp_d;
    logic [DATA_WIDTH-1:0] sym_q, sym_d;
    logic                  valid_q, valid_d;
    logic [10:0]           addr_q, addr_d;

    logic [5:0]            grp_next;
    logic [10:0]           n_clamped;
    logic [2:0]            qm_decoded;

    // One axis of the constellation: sign bit s, magnitude bits m_hi/m_lo (64QAM Gray order).
    function automatic logic [8:0] axis_level(input logic [2:0] qm, input logic s,
                                              input logic m_hi, input logic m_lo);
        logic [8:0] mag;
        case (qm)
            3'd4:    mag = m_hi ? 9'd121 : 9'd40;
            3'd6: begin
                case ({m_hi, m_lo})
                    2'b00:   mag = 9'd59;
                    2'b01:   mag = 9'd20;
                    2'b10:   mag = 9'd99;
                    default: mag = 9'd138;
                endcase
            end
            default: mag = 9'd91;
        endcase
        return s ? (~mag + 9'd1) : mag;
    endfunction

    always_comb begin
        case (mod_order)
            2'd1:    qm_decoded = 3'd4;
            2'd2:    qm_decoded = 3'd6;
            default: qm_decoded = 3'd2;
        endcase
    end

    assign n_clamped = (32'(num_symbols) > MEM_DEPTH) ? 11'(MEM_DEPTH) : num_symbols;

    // The group including the bit arriving now, so the symbol lands one cycle after its last bit.
    always_comb begin
        grp_next            = grp_q;
        grp_next[bit_cnt_q] = bit_in;
    end

    always_comb begin
        state_d   = state_q;
        qm_d      = qm_q;
        n_d       = n_q;
        bit_cnt_d = bit_cnt_q;
        sym_cnt_d = sym_cnt_q;
        grp_d     = grp_q;
        sym_d     = sym_q;
        valid_d   = 1'b0;
        addr_d    = addr_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    qm_d      = qm_decoded;
                    n_d       = n_clamped;
                    bit_cnt_d = 3'd0;
                    sym_cnt_d = 11'd0;
                    grp_d     = 6'd0;
                    if (n_clamped != 11'd0) begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (sym_cnt_q == n_q) begin
                    state_d = StDone;
                end else if (bit_valid) begin
                    if (bit_cnt_q == qm_q - 3'd1) begin
                        sym_d = DATA_WIDTH'({
                            axis_level(qm_q, grp_next[0], grp_next[2], grp_next[4]),
                            axis_level(qm_q, grp_next[1], grp_next[3], grp_next[5])
                        });
                        valid_d   = 1'b1;
                        addr_d    = sym_cnt_q + 11'd1;
                        sym_cnt_d = sym_cnt_q + 11'd1;
                        bit_cnt_d = 3'd0;
                        grp_d     = 6'd0;
                    end else begin
                        grp_d     = grp_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                addr_d  = 11'd0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            qm_q      <= 3'd2;
            n_q       <= 11'd0;
            bit_cnt_q <= 3'd0;
            sym_cnt_q <= 11'd0;
            grp_q     <= 6'd0;
            sym_q     <= '0;
            valid_q   <= 1'b0;
            addr_q    <= 11'd0;
        end else begin
            state_q   <= state_d;
            qm_q      <= qm_d;
            n_q       <= n_d;
            bit_cnt_q <= bit_cnt_d;
            sym_cnt_q <= sym_cnt_d;
            grp_q     <= grp_d;
            sym_q     <= sym_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
        end
    end

    assign sym_out         = sym_q;
    assign Mod_Valid_OUT   = valid_q;
    assign write_enable    = valid_q;
    assign write_addr      = addr_q;
    assign MOD_DONE        = (state_q == StDone);
    assign PINGPONG_SWITCH = (state_q == StDone);
    assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_pusch_mod_mapper.sv
// Bench for pusch_mod_mapper: directed bit streams, a cycle-tagged expectation model and one
// per-cycle compare process, plus literal checks on key symbols and counts.
module tb_pusch_mod_mapper;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mod_order = 2'd0;
    logic [10:0] num_symbols = 11'd0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic [17:0] sym_out;
    logic        Mod_Valid_OUT, write_enable, MOD_DONE, PINGPONG_SWITCH, busy;
    logic [10:0] write_addr;

    pusch_mod_mapper dut (
        .CLK             (CLK),
        .RST             (RST),
        .start           (start),
        .mod_order       (mod_order),
        .num_symbols     (num_symbols),
        .bit_in          (bit_in),
        .bit_valid       (bit_valid),
        .sym_out         (sym_out),
        .Mod_Valid_OUT   (Mod_Valid_OUT),
        .write_enable    (write_enable),
        .write_addr      (write_addr),
        .MOD_DONE        (MOD_DONE),
        .PINGPONG_SWITCH (PINGPONG_SWITCH),
        .busy            (busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected symbol writes and done pulses, tagged with the cycle they must be visible in.
    typedef struct {
        logic [17:0] sym;
        logic [10:0] addr;
        int          due;
    } exp_t;
    exp_t eq[$];
    int   dq[$];

    bit         m_collect  = 0;
    int         m_qm       = 2;
    int         m_n        = 0;
    int         m_sym      = 0;
    int         m_bc       = 0;
    int         m_from     = 0;
    int         m_done_cyc = -10;
    logic [5:0] m_bits     = '0;

    // Constellation from 38.211 amplitudes scaled by 128, rounded.
    function automatic logic [8:0] model_axis(input int qm, input logic s, input logic a,
                                              input logic b);
        real scale;
        real amp;
        real sa, sb;
        int  lvl;
        sa = a ? -1.0 : 1.0;
        sb = b ? -1.0 : 1.0;
        if (qm == 4) begin
            scale = 128.0 / $sqrt(10.0);
            amp   = 2.0 - sa;
        end else if (qm == 6) begin
            scale = 128.0 / $sqrt(42.0);
            amp   = 4.0 - sa * (2.0 - sb);
        end else begin
            scale = 128.0 / $sqrt(2.0);
            amp   = 1.0;
        end
        lvl = $rtoi(amp * scale + 0.5);
        return s ? 9'(-lvl) : 9'(lvl);
    endfunction

    function automatic logic [17:0] model_sym(input int qm, input logic [5:0] g);
        return {model_axis(qm, g[0], g[2], g[4]), model_axis(qm, g[1], g[3], g[5])};
    endfunction

    // Observation state filled by the compare process.
    int          vcount = 0;
    int          dcount = 0;
    logic [10:0] first_addr = '0;
    logic [10:0] last_addr  = '0;

    always @(negedge CLK) begin
        bit exp_v;
        bit exp_d;
        if (!RST) begin
            chk("reset_outputs", {Mod_Valid_OUT, write_enable, MOD_DONE, PINGPONG_SWITCH, busy,
                                  write_addr}, 32'd0);
            chk("reset_sym", sym_out, 32'd0);
        end else begin
            exp_v = (eq.size() > 0) && (eq[0].due == cyc);
            chk("valid", Mod_Valid_OUT, exp_v);
            chk("write_enable", write_enable, exp_v);
            if (exp_v) begin
                chk("sym_out", sym_out, eq[0].sym);
                chk("write_addr", write_addr, eq[0].addr);
                void'(eq.pop_front());
            end
            if (Mod_Valid_OUT) begin
                vcount++;
                if (vcount == 1) first_addr = write_addr;
                last_addr = write_addr;
            end
            exp_d = (dq.size() > 0) && (dq[0] == cyc);
            chk("mod_done", MOD_DONE, exp_d);
            chk("pingpong_switch", PINGPONG_SWITCH, exp_d);
            if (exp_d) void'(dq.pop_front());
            if (MOD_DONE) dcount++;
        end
    end

    // One clock of stimulus; the model decides what the DUT must do with it.
    task automatic drive(input bit st, input logic [1:0] mo, input int ns, input bit bv,
                         input bit b);
        int  c;
        bit  take_start;
        @(posedge CLK);
        #1;
        start       = st;
        mod_order   = mo;
        num_symbols = 11'(ns);
        bit_valid   = bv;
        bit_in      = b;
        c           = cyc;
        take_start  = st && !m_collect && (c > m_done_cyc);
        if (take_start) begin
            m_qm = (mo == 2'd1) ? 4 : (mo == 2'd2) ? 6 : 2;
            m_n  = (ns > 1200) ? 1200 : ns;
            if (m_n > 0) begin
                m_collect = 1;
                m_from    = c + 1;
                m_sym     = 0;
                m_bc      = 0;
                m_bits    = '0;
            end
        end
        if (bv && m_collect && c >= m_from) begin
            m_bits[m_bc] = b;
            m_bc++;
            if (m_bc == m_qm) begin
                m_sym++;
                eq.push_back('{model_sym(m_qm, m_bits), 11'(m_sym), c + 1});
                m_bc   = 0;
                m_bits = '0;
                if (m_sym == m_n) begin
                    m_collect  = 0;
                    m_done_cyc = c + 2;
                    dq.push_back(c + 2);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 2'd0, 0, 0, 0);
    endtask

    task automatic send_word(input logic [63:0] w, input int nb);
        for (int i = 0; i < nb; i++) drive(0, 2'd0, 0, 1, w[i]);
    endtask

    task automatic clear_obs();
        vcount     = 0;
        dcount     = 0;
        first_addr = '0;
        last_addr  = '0;
    endtask

    // Bounded drain: every queued expectation must have been consumed by now.
    task automatic finish_test(input string name);
        idle(6);
        chk({name, "_drained_syms"}, eq.size(), 32'd0);
        chk({name, "_drained_done"}, dq.size(), 32'd0);
        chk({name, "_addr_idle"}, write_addr, 32'd0);
        eq.delete();
        dq.delete();
    endtask

    task automatic apply_reset(input int n);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        eq.delete();
        dq.delete();
        m_collect  = 0;
        m_done_cyc = -10;
        for (int i = 0; i < n; i++) drive(0, 2'd0, 0, 0, 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        idle(2);
        chk("post_reset_busy", busy, 32'd0);
        chk("post_reset_sym", sym_out, 32'd0);

        // QPSK N=1, bits 0,0; trailing bits after the block must be dropped.
        clear_obs();
        drive(1, 2'd0, 1, 0, 0);
        send_word(64'h0, 2);
        send_word(64'h3, 2);
        finish_test("qpsk1");
        chk("qpsk1_sym", sym_out, {9'd91, 9'd91});
        chk("qpsk1_count", vcount, 32'd1);
        chk("qpsk1_addr", last_addr, 32'd1);
        chk("qpsk1_done", dcount, 32'd1);

        // 16QAM bits 1,0,1,1 -> I=-121, Q=+121.
        clear_obs();
        drive(1, 2'd1, 1, 0, 0);
        send_word(64'hD, 4);
        finish_test("qam16");
        chk("qam16_sym", sym_out, {9'h187, 9'h079});
        chk("qam16_count", vcount, 32'd1);

        // 64QAM N=2: all zeros then all ones.
        clear_obs();
        drive(1, 2'd2, 2, 0, 0);
        send_word(64'h00, 6);
        send_word(64'h3F, 6);
        send_word(64'h3F, 3);
        finish_test("qam64");
        chk("qam64_sym", sym_out, {9'h176, 9'h176});
        chk("qam64_count", vcount, 32'd2);
        chk("qam64_addr", last_addr, 32'd2);
        chk("qam64_done", dcount, 32'd1);

        // QPSK N=3 with a gap after every bit; partial groups must survive the gaps.
        clear_obs();
        drive(1, 2'd0, 3, 0, 0);
        begin
            logic [5:0] pat;
            pat = 6'b110110;
            for (int i = 0; i < 6; i++) begin
                drive(0, 2'd0, 0, 1, pat[i]);
                drive(0, 2'd0, 0, 0, 1);
            end
        end
        finish_test("gaps");
        chk("gaps_count", vcount, 32'd3);
        chk("gaps_first", first_addr, 32'd1);
        chk("gaps_last", last_addr, 32'd3);
        chk("gaps_done", dcount, 32'd1);

        // num_symbols=2000 clamps to 1200 (reserved order -> QPSK); a start mid-block is ignored.
        clear_obs();
        drive(1, 2'd3, 2000, 0, 0);
        for (int i = 0; i < 2400; i++) begin
            if (i == 700) drive(1, 2'd2, 5, 1, 1'($urandom));
            else drive(0, 2'd0, 0, 1, 1'($urandom));
        end
        finish_test("clamp");
        chk("clamp_count", vcount, 32'd1200);
        chk("clamp_last", last_addr, 32'd1200);
        chk("clamp_done", dcount, 32'd1);

        // num_symbols=0: nothing happens.
        clear_obs();
        drive(1, 2'd0, 0, 0, 0);
        chk("n0_busy", busy, 32'd0);
        send_word(64'h5, 4);
        finish_test("n0");
        chk("n0_count", vcount, 32'd0);
        chk("n0_done", dcount, 32'd0);

        // Reset after 5 of 10 symbols; no MOD_DONE, and the next block restarts at address 1.
        clear_obs();
        drive(1, 2'd0, 10, 0, 0);
        send_word(64'h2D9, 10);
        idle(2);
        chk("abort_count", vcount, 32'd5);
        apply_reset(2);
        idle(4);
        chk("abort_done", dcount, 32'd0);
        clear_obs();
        drive(1, 2'd1, 2, 0, 0);
        send_word(64'h6B, 8);
        finish_test("restart");
        chk("restart_first", first_addr, 32'd1);
        chk("restart_count", vcount, 32'd2);
        chk("restart_done", dcount, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
